// File: rtl/cache_ctrl_assoc_if.sv
// Request/response and refill bus for the set-associative read cache.
// The slave side is the cache controller, the master side its environment.
interface cache_ctrl_assoc_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_addr, flush, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_hit, resp_data,
        input  mem_req, mem_addr
    );

    modport slave (
        input  req_valid, req_addr, flush, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_hit, resp_data,
        output mem_req, mem_addr
    );
endinterface

// File: rtl/cache_ctrl_assoc.sv
// Set-associative read-only cache controller, one word per line,
// LRU replacement, req/ack refill port and saturating hit/miss counters.
module cache_ctrl_assoc #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_ctrl_assoc_if.slave   bus,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        FILL
    } state_t;

    state_t state;
    state_t state_nx;

    logic              vld  [WAYS][SETS];
    logic [TAG_W-1:0]  tags [WAYS][SETS];
    logic [DATA_W-1:0] lines[WAYS][SETS];
    logic              lru  [SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic [INDEX_W-1:0] fidx;
    logic [TAG_W-1:0]   ftag;
    logic               accept;
    logic               hit;
    logic [WW-1:0]      hit_way;
    logic [DATA_W-1:0]  hit_data;
    logic [WW-1:0]      victim;
    logic [WW-1:0]      vic;
    logic               fill_now;

    assign idx  = bus.req_addr[INDEX_W-1:0];
    assign tg   = bus.req_addr[ADDR_W-1:INDEX_W];
    assign fidx = bus.mem_addr[INDEX_W-1:0];
    assign ftag = bus.mem_addr[ADDR_W-1:INDEX_W];

    assign bus.req_ready = (state == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign fill_now      = (state == MISS_REQ) && bus.mem_ack;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld[w][idx] && tags[w][idx] == tg) begin
                hit      = 1'b1;
                hit_way  = WW'(w);
                hit_data = lines[w][idx];
            end
        end
    end

    // Invalid ways are filled before anything is evicted.
    always_comb begin
        victim = '0;
        if (WAYS > 1) begin
            if (!vld[0][idx])
                victim = '0;
            else if (!vld[WAYS-1][idx])
                victim = WW'(1);
            else
                victim = WW'(lru[idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (accept && !hit) state_nx = MISS_REQ;
            MISS_REQ: if (bus.mem_ack)    state_nx = FILL;
            FILL:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_data  <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            vic            <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    vld[w][s] <= 1'b0;
            for (int s = 0; s < SETS; s++)
                lru[s] <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (state == IDLE && bus.flush) begin
                for (int w = 0; w < WAYS; w++)
                    for (int s = 0; s < SETS; s++)
                        vld[w][s] <= 1'b0;
            end else if (accept && hit) begin
                bus.resp_valid <= 1'b1;
                bus.resp_hit   <= 1'b1;
                bus.resp_data  <= hit_data;
                if (WAYS > 1)
                    lru[idx] <= ~hit_way[0];
                if (hit_cnt != '1)
                    hit_cnt <= hit_cnt + 1'b1;
            end else if (accept) begin
                bus.mem_req  <= 1'b1;
                bus.mem_addr <= bus.req_addr;
                vic          <= victim;
                if (miss_cnt != '1)
                    miss_cnt <= miss_cnt + 1'b1;
            end
            if (fill_now) begin
                bus.mem_req    <= 1'b0;
                bus.resp_valid <= 1'b1;
                bus.resp_hit   <= 1'b0;
                bus.resp_data  <= bus.mem_rdata;
                vld[vic][fidx] <= 1'b1;
                if (WAYS > 1)
                    lru[fidx] <= ~vic[0];
            end
        end
    end

    // Tag and data storage is only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && fill_now) begin
            tags[vic][fidx]  <= ftag;
            lines[vic][fidx] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc: misses, hits, LRU eviction,
// flush, reset during a refill and counter saturation.
module tb_cache_ctrl_assoc;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic          o_rv;
    logic          o_rh;
    logic [DW-1:0] o_rd;

    cache_ctrl_assoc_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_ctrl_assoc #(
        .ADDR_W(AW), .DATA_W(DW), .INDEX_W(4), .WAYS(2), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic complete(input int dly, input logic [DW-1:0] d);
        repeat (dly) step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = d;
        step();
        bus.mem_ack = 1'b0;
        o_rv = bus.resp_valid;
        o_rh = bus.resp_hit;
        o_rd = bus.resp_data;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.resp_valid, bus.resp_hit, bus.mem_req} !== 3'b000 ||
            bus.resp_data !== '0 || bus.mem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rv%b rh%b mr%b d%h a%h want zeros",
                     bus.resp_valid, bus.resp_hit, bus.mem_req,
                     bus.resp_data, bus.mem_addr);
        end
        vectors++;
        if (hit_cnt !== 0 || miss_cnt !== 0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_counts: got h%0d m%0d rdy%b want 0 0 1",
                     hit_cnt, miss_cnt, bus.req_ready);
        end
    endtask

    task automatic test_cold_miss();
        issue(15'h0012);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'h0012 ||
            miss_cnt !== 1 || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cold_miss_req: got mr%b a%h m%0d rdy%b want 1 0012 1 0",
                     bus.mem_req, bus.mem_addr, miss_cnt, bus.req_ready);
        end
        bus.req_addr = 15'h7fff;
        repeat (2) step();
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'h0012) begin
            miscompares++;
            $display("FAIL cold_miss_hold: got mr%b a%h want 1 0012",
                     bus.mem_req, bus.mem_addr);
        end
        complete(1, 32'hDEADBEEF);
        vectors++;
        if (o_rv !== 1'b1 || o_rh !== 1'b0 || o_rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL cold_miss_resp: got v%b h%b d%h want 1 0 deadbeef",
                     o_rv, o_rh, o_rd);
        end
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0 ||
            bus.req_ready !== 1'b1 || bus.resp_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL cold_miss_after: got v%b mr%b rdy%b d%h want 0 0 1 deadbeef",
                     bus.resp_valid, bus.mem_req, bus.req_ready, bus.resp_data);
        end
    endtask

    task automatic test_hit();
        issue(15'h0012);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 ||
            bus.resp_data !== 32'hDEADBEEF || hit_cnt !== 1 ||
            bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL hit: got v%b h%b d%h hc%0d mr%b want 1 1 deadbeef 1 0",
                     bus.resp_valid, bus.resp_hit, bus.resp_data,
                     hit_cnt, bus.mem_req);
        end
    endtask

    task automatic test_back_to_back();
        bus.req_valid = 1'b1;
        bus.req_addr = 15'h0012;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 ||
                bus.req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_%0d: got v%b h%b rdy%b want 1 1 1",
                         i, bus.resp_valid, bus.resp_hit, bus.req_ready);
            end
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (hit_cnt !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 4", hit_cnt);
        end
    endtask

    task automatic test_flush();
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 15'h0012;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got %b want 0", bus.req_ready);
        end
        step();
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_blocks_req: got v%b mr%b want 0 0",
                     bus.resp_valid, bus.mem_req);
        end
        issue(15'h0012);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0 || miss_cnt !== 2) begin
            miscompares++;
            $display("FAIL flush_miss: got mr%b v%b m%0d want 1 0 2",
                     bus.mem_req, bus.resp_valid, miss_cnt);
        end
        complete(0, 32'hCAFEF00D);
        vectors++;
        if (o_rv !== 1'b1 || o_rh !== 1'b0 || o_rd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL flush_refill: got v%b h%b d%h want 1 0 cafef00d",
                     o_rv, o_rh, o_rd);
        end
    endtask

    task automatic test_lru();
        do_reset();
        issue(15'h0012);
        complete(0, 32'hA0A0A0A0);
        issue(15'h0412);
        complete(2, 32'hB1B1B1B1);
        issue(15'h0012);
        vectors++;
        if (bus.resp_hit !== 1'b1 || bus.resp_data !== 32'hA0A0A0A0) begin
            miscompares++;
            $display("FAIL lru_touch: got h%b d%h want 1 a0a0a0a0",
                     bus.resp_hit, bus.resp_data);
        end
        issue(15'h0812);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'h0812) begin
            miscompares++;
            $display("FAIL lru_miss: got mr%b a%h want 1 0812",
                     bus.mem_req, bus.mem_addr);
        end
        complete(1, 32'hC2C2C2C2);
        issue(15'h0012);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 ||
            bus.resp_data !== 32'hA0A0A0A0) begin
            miscompares++;
            $display("FAIL lru_keep: got v%b h%b d%h want 1 1 a0a0a0a0",
                     bus.resp_valid, bus.resp_hit, bus.resp_data);
        end
        issue(15'h0412);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lru_evicted: got mr%b v%b want 1 0",
                     bus.mem_req, bus.resp_valid);
        end
        complete(0, 32'hB1B1B1B1);
        vectors++;
        if (hit_cnt !== 2 || miss_cnt !== 4) begin
            miscompares++;
            $display("FAIL lru_counts: got h%0d m%0d want 2 4", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        issue(15'h0020);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1 ||
            hit_cnt !== 0 || miss_cnt !== 0) begin
            miscompares++;
            $display("FAIL rst_mid: got mr%b rdy%b h%0d m%0d want 0 1 0 0",
                     bus.mem_req, bus.req_ready, hit_cnt, miss_cnt);
        end
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();
        bus.mem_ack = 1'b0;
        vectors++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL late_ack: got v%b rdy%b want 0 1",
                     bus.resp_valid, bus.req_ready);
        end
        issue(15'h0012);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_invalid: got mr%b v%b want 1 0",
                     bus.mem_req, bus.resp_valid);
        end
        complete(0, 32'h0);
    endtask

    task automatic test_saturation();
        do_reset();
        issue(15'h0005);
        complete(0, 32'h55AA55AA);
        bus.req_valid = 1'b1;
        bus.req_addr = 15'h0005;
        repeat (20) step();
        bus.req_valid = 1'b0;
        vectors++;
        if (hit_cnt !== 4'd15 || miss_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL saturation: got h%0d m%0d want 15 1", hit_cnt, miss_cnt);
        end
        vectors++;
        if (bus.resp_data !== 32'h55AA55AA || bus.resp_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_data: got d%h h%b want 55aa55aa 1",
                     bus.resp_data, bus.resp_hit);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_flush();
        test_lru();
        test_reset_mid_miss();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
